// File: rtl/cic_decimator.sv
// cic_decimator: programmable-ratio (R = 1,2,4,8,16) Hogenauer CIC decimator
// with gain normalisation, round-half-up and saturation to the Q1.15 format.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_in, cic_in    input sample strobe and signed sample
//   dec_factor          ratio select (0..4 -> R=2^n, 5..7 -> R=16)
//   bypass              pass cic_in straight through with 1-cycle latency
//   cic_out, valid_out  decimated sample and its one-cycle strobe
//   overflow, underflow saturation flags, pulse with valid_out
// Optional macro CIC_SAT_CNT_EN adds sat_count (out, 16) and
// sat_count_clr (in, 1): a saturating count of saturation events.
module cic_decimator #(
    parameter int DATA_WIDTH   = 16,
    parameter int DATA_FRAC    = 15,
    parameter int N_STAGE      = 5,
    parameter int MAX_DEC_LOG2 = 4,
    parameter int ACC_WIDTH    = DATA_WIDTH + N_STAGE * MAX_DEC_LOG2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] cic_in,
    input  logic [2:0]                   dec_factor,
    input  logic                         bypass,
`ifdef CIC_SAT_CNT_EN
    input  logic                         sat_count_clr,
    output logic [15:0]                  sat_count,
`endif
    output logic signed [DATA_WIDTH-1:0] cic_out,
    output logic                         valid_out,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW  = ACC_WIDTH;
    localparam int SHW = $clog2(N_STAGE * MAX_DEC_LOG2 + 1);

    // Q1.x format: one sign bit, so full scale is 2^DATA_FRAC LSBs.
    localparam logic signed [AW:0] SMAX =
        (AW+1)'((64'sd1 <<< DATA_FRAC) - 64'sd1);
    localparam logic signed [AW:0] SMIN =
        (AW+1)'(-(64'sd1 <<< DATA_FRAC));

    logic [2:0]                   dec_log2;
    logic [2:0]                   r_q;
    logic                         flush;
    logic [MAX_DEC_LOG2-1:0]      cnt_q;
    logic [MAX_DEC_LOG2-1:0]      cnt_max;
    logic                         dec_evt;

    logic signed [AW-1:0]         in_ext;
    logic signed [AW-1:0]         integ_q [N_STAGE];
    logic signed [AW-1:0]         dly_q   [N_STAGE];
    logic signed [AW-1:0]         dly_d   [N_STAGE];
    logic signed [AW-1:0]         comb_acc;

    logic [SHW-1:0]               shamt;
    logic signed [AW:0]           c_ext;
    logic signed [AW:0]           rnd;
    logic signed [AW:0]           s_val;
    logic signed [DATA_WIDTH-1:0] out_d;
    logic                         ov_d;
    logic                         un_d;

    logic signed [DATA_WIDTH-1:0] out_q;
    logic                         vld_q;
    logic                         ov_q;
    logic                         un_q;

    // Out-of-range selects clamp to the largest supported ratio.
    always_comb begin
        dec_log2 = dec_factor;
        if (dec_factor > 3'(MAX_DEC_LOG2)) begin
            dec_log2 = 3'(MAX_DEC_LOG2);
        end
    end

    assign flush   = (dec_log2 != r_q);
    assign cnt_max = ~({MAX_DEC_LOG2{1'b1}} << r_q);
    assign dec_evt = valid_in && (cnt_q == cnt_max);
    assign in_ext  = {{(AW-DATA_WIDTH){cic_in[DATA_WIDTH-1]}}, cic_in};

    // Comb chain walked from I_N; dly_d[k] is the input of stage k,
    // which is what that stage's delay must remember.
    always_comb begin
        comb_acc = integ_q[N_STAGE-1];
        for (int k = 0; k < N_STAGE; k++) begin
            dly_d[k] = comb_acc;
            comb_acc = comb_acc - dly_q[k];
        end
    end

    // Gain is R^N = 2^(N*log2 R). The rounding constant is half an
    // output LSB, and collapses to zero when the shift is zero.
    always_comb begin
        shamt = SHW'(N_STAGE) * SHW'(r_q);
        c_ext = {comb_acc[AW-1], comb_acc};
        rnd   = ({{AW{1'b0}}, 1'b1} << shamt) >> 1;
        s_val = (c_ext + rnd) >>> shamt;
        ov_d  = (s_val > SMAX);
        un_d  = (s_val < SMIN);
        out_d = s_val[DATA_WIDTH-1:0];
        if (ov_d) begin
            out_d = SMAX[DATA_WIDTH-1:0];
        end else if (un_d) begin
            out_d = SMIN[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= dec_log2;
            cnt_q <= '0;
            for (int k = 0; k < N_STAGE; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
            out_q <= '0;
            vld_q <= 1'b0;
            ov_q  <= 1'b0;
            un_q  <= 1'b0;
        end else if (flush || bypass) begin
            // Ratio change or bypass: filter state is held clear so the
            // next decimated group starts from zero history.
            r_q   <= dec_log2;
            cnt_q <= '0;
            for (int k = 0; k < N_STAGE; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
            ov_q  <= 1'b0;
            un_q  <= 1'b0;
            vld_q <= 1'b0;
            if (!flush) begin
                vld_q <= valid_in;
                if (valid_in) begin
                    out_q <= cic_in;
                end
            end
        end else begin
            vld_q <= 1'b0;
            ov_q  <= 1'b0;
            un_q  <= 1'b0;
            if (valid_in) begin
                integ_q[0] <= integ_q[0] + in_ext;
                for (int k = 1; k < N_STAGE; k++) begin
                    integ_q[k] <= integ_q[k] + integ_q[k-1];
                end
                cnt_q <= dec_evt ? '0 : cnt_q + 1'b1;
                if (dec_evt) begin
                    for (int k = 0; k < N_STAGE; k++) begin
                        dly_q[k] <= dly_d[k];
                    end
                    out_q <= out_d;
                    vld_q <= 1'b1;
                    ov_q  <= ov_d;
                    un_q  <= un_d;
                end
            end
        end
    end

    assign cic_out   = out_q;
    assign valid_out = vld_q;
    assign overflow  = ov_q;
    assign underflow = un_q;

`ifdef CIC_SAT_CNT_EN
    logic [15:0] sat_cnt_q;

    // Counts visible flag pulses; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || sat_count_clr) begin
            sat_cnt_q <= '0;
        end else if ((ov_q || un_q) && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_count = sat_cnt_q;
`endif

endmodule
